// File: rtl/gpio_bus_pkg.sv
// Shared types and default timing for the external test-board bus master.
package gpio_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    TURN
  } gpio_state_t;

  localparam int DEF_ADDR_W     = 11;
  localparam int DEF_DATA_W     = 16;
  localparam int DEF_SETUP_CYC  = 1;
  localparam int DEF_STROBE_CYC = 2;
  localparam int DEF_HOLD_CYC   = 1;
  localparam int DEF_TURN_CYC   = 1;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/gpio_bus_master.sv
// Sequences single-word read/write requests as setup/strobe/hold cycles on the
// shared test-board bus; this block owns the GPIO pins.
module gpio_bus_master
  import gpio_bus_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int SETUP_CYC  = DEF_SETUP_CYC,
  parameter int STROBE_CYC = DEF_STROBE_CYC,
  parameter int HOLD_CYC   = DEF_HOLD_CYC,
  parameter int TURN_CYC   = DEF_TURN_CYC
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  inout  wire  [DATA_W-1:0] gpio_data,
  output logic [ADDR_W-1:0] gpio_addr,
  output logic              gpio_wr_en,
  output logic              gpio_rd_en
);

  localparam int CNT_W = $clog2(max4(SETUP_CYC, STROBE_CYC, HOLD_CYC, TURN_CYC)) + 1;

  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] TURN_LD   = CNT_W'(TURN_CYC - 1);

  if (SETUP_CYC < 1 || STROBE_CYC < 1 || HOLD_CYC < 1 || TURN_CYC < 1) begin : g_bad_timing
    $error("gpio_bus_master: all timing parameters must be >= 1");
  end

  gpio_state_t       state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              wr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              drive_en;
  logic              accept;
  logic              cur_write;
  logic              rd_sample;
  logic              drive_nxt;

  assign busy      = (state != IDLE);
  assign gpio_data = drive_en ? wdata_q : 'z;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // req_ready is a flop, so the first edge after reset release never accepts.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = (state == IDLE) && req_ready && req_valid;
    case (state)
      IDLE: if (accept) begin
        state_nxt = SETUP;
        cnt_nxt   = SETUP_LD;
      end
      SETUP: if (cnt == '0) begin
        state_nxt = STROBE;
        cnt_nxt   = STROBE_LD;
      end else cnt_nxt = cnt - 1'b1;
      STROBE: if (cnt == '0) begin
        state_nxt = HOLD;
        cnt_nxt   = HOLD_LD;
      end else cnt_nxt = cnt - 1'b1;
      HOLD: if (cnt == '0) begin
        state_nxt = wr_q ? IDLE : TURN;
        cnt_nxt   = wr_q ? '0 : TURN_LD;
      end else cnt_nxt = cnt - 1'b1;
      TURN: if (cnt == '0) begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end else cnt_nxt = cnt - 1'b1;
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Pin-facing outputs are registered from the next state so they switch cleanly on the edge.
  always_comb begin
    cur_write = accept ? req_write : wr_q;
    rd_sample = (state == STROBE) && (cnt == '0) && !wr_q;
    drive_nxt = cur_write &&
                (state_nxt == SETUP || state_nxt == STROBE || state_nxt == HOLD);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_ready  <= 1'b0;
      wr_q       <= 1'b0;
      wdata_q    <= '0;
      gpio_addr  <= '0;
      gpio_wr_en <= 1'b0;
      gpio_rd_en <= 1'b0;
      drive_en   <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
    end else begin
      req_ready  <= (state_nxt == IDLE);
      gpio_wr_en <= cur_write && (state_nxt == STROBE);
      gpio_rd_en <= !cur_write && (state_nxt == STROBE);
      drive_en   <= drive_nxt;
      rsp_valid  <= rd_sample;
      if (accept) begin
        wr_q      <= req_write;
        wdata_q   <= req_wdata;
        gpio_addr <= req_addr;
      end
      if (rd_sample) rsp_rdata <= gpio_data;
    end
  end

endmodule

// File: tb/tb_gpio_bus_master.sv
// Directed bench for gpio_bus_master: default-timing DUT with a board read model,
// plus a second instance with stretched setup/hold timing.
module tb_gpio_bus_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        req_valid, req_write;
  logic [10:0] req_addr;
  logic [15:0] req_wdata;
  logic        req_ready, rsp_valid, busy, gpio_wr_en, gpio_rd_en;
  logic [15:0] rsp_rdata;
  logic [10:0] gpio_addr;
  wire  [15:0] gpio_bus;
  logic [15:0] board_val;

  // Board answers a read by driving the bus while the read strobe is high.
  assign gpio_bus = gpio_rd_en ? board_val : 'z;

  gpio_bus_master dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
    .gpio_data(gpio_bus), .gpio_addr(gpio_addr),
    .gpio_wr_en(gpio_wr_en), .gpio_rd_en(gpio_rd_en)
  );

  logic        v5, w5, r5, rv5, b5, we5, re5;
  logic [10:0] a5, ga5;
  logic [15:0] d5, rd5;
  wire  [15:0] bus5;

  gpio_bus_master #(.SETUP_CYC(3), .STROBE_CYC(1), .HOLD_CYC(2)) u5 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(v5), .req_ready(r5), .req_write(w5),
    .req_addr(a5), .req_wdata(d5),
    .rsp_valid(rv5), .rsp_rdata(rd5), .busy(b5),
    .gpio_data(bus5), .gpio_addr(ga5),
    .gpio_wr_en(we5), .gpio_rd_en(re5)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int overlap = 0;
  int rsp_cnt = 0;

  always @(posedge clk) begin
    #2;
    if (gpio_rd_en && dut.drive_en) overlap++;
    if (rsp_valid) rsp_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    int r0;
    int wr_first, wr_cnt, drv_cnt, rdy_first;
    reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    board_val = 16'h1234;
    v5 = 1'b0; w5 = 1'b0; a5 = '0; d5 = '0;

    // reset values
    cyc(); cyc();
    chk("rst_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr", gpio_addr, 0);
    chk("rst_wr", gpio_wr_en, 0);
    chk("rst_rd", gpio_rd_en, 0);
    chk("rst_drive", dut.drive_en, 0);
    reset_n = 1'b1;
    cyc();
    chk("rel_ready", req_ready, 1);

    // 1: default write
    req_valid = 1'b1; req_write = 1'b1; req_addr = 11'h155; req_wdata = 16'hBEEF;
    cyc(); req_valid = 1'b0;
    chk("t1_c1_addr", gpio_addr, 11'h155);
    chk("t1_c1_data", gpio_bus, 16'hBEEF);
    chk("t1_c1_wr", gpio_wr_en, 0);
    chk("t1_c1_busy", busy, 1);
    chk("t1_c1_ready", req_ready, 0);
    cyc();
    chk("t1_c2_wr", gpio_wr_en, 1);
    chk("t1_c2_data", gpio_bus, 16'hBEEF);
    cyc();
    chk("t1_c3_wr", gpio_wr_en, 1);
    cyc();
    chk("t1_c4_wr", gpio_wr_en, 0);
    chk("t1_c4_data", gpio_bus, 16'hBEEF);
    chk("t1_c4_addr", gpio_addr, 11'h155);
    chk("t1_c4_ready", req_ready, 0);
    cyc();
    chk("t1_c5_ready", req_ready, 1);
    chk("t1_c5_busy", busy, 0);
    chk("t1_c5_drive", dut.drive_en, 0);

    // 2: read from board
    r0 = rsp_cnt;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 11'h7FF;
    cyc(); req_valid = 1'b0;
    chk("t2_c1_rd", gpio_rd_en, 0);
    chk("t2_c1_drive", dut.drive_en, 0);
    chk("t2_c1_addr", gpio_addr, 11'h7FF);
    cyc();
    chk("t2_c2_rd", gpio_rd_en, 1);
    chk("t2_c2_bus", gpio_bus, 16'h1234);
    chk("t2_c2_drive", dut.drive_en, 0);
    cyc();
    chk("t2_c3_rd", gpio_rd_en, 1);
    cyc();
    chk("t2_c4_rd", gpio_rd_en, 0);
    chk("t2_c4_rsp", rsp_valid, 1);
    chk("t2_c4_rdata", rsp_rdata, 16'h1234);
    cyc();
    chk("t2_c5_rsp", rsp_valid, 0);
    chk("t2_c5_busy", busy, 1);
    chk("t2_c5_ready", req_ready, 0);
    chk("t2_c5_drive", dut.drive_en, 0);
    cyc();
    chk("t2_c6_ready", req_ready, 1);
    chk("t2_c6_busy", busy, 0);
    chk("t2_pulses", rsp_cnt - r0, 1);

    // 3: read followed by a write held valid
    board_val = 16'hA5A5;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 11'h010;
    cyc();
    req_write = 1'b1; req_addr = 11'h020; req_wdata = 16'h5A5A;
    chk("t3_c1_busy", busy, 1);
    chk("t3_c1_ready", req_ready, 0);
    cyc(); chk("t3_c2_rd", gpio_rd_en, 1);
    cyc();
    cyc();
    chk("t3_c4_rsp", rsp_valid, 1);
    chk("t3_c4_rdata", rsp_rdata, 16'hA5A5);
    cyc();
    chk("t3_c5_ready", req_ready, 0);
    chk("t3_c5_drive", dut.drive_en, 0);
    cyc();
    chk("t3_c6_ready", req_ready, 1);
    chk("t3_c6_drive", dut.drive_en, 0);
    cyc(); req_valid = 1'b0;
    chk("t3_c7_busy", busy, 1);
    chk("t3_c7_addr", gpio_addr, 11'h020);
    chk("t3_c7_drive", dut.drive_en, 1);
    chk("t3_c7_data", gpio_bus, 16'h5A5A);
    cyc(); cyc(); cyc(); cyc();
    chk("t3_c11_ready", req_ready, 1);
    chk("t3_overlap", overlap, 0);

    // 4: reset during write strobe, then release together with a request
    req_valid = 1'b1; req_write = 1'b1; req_addr = 11'h3C3; req_wdata = 16'h0F0F;
    cyc(); req_valid = 1'b0;
    cyc();
    chk("t4_c2_wr", gpio_wr_en, 1);
    r0 = rsp_cnt;
    reset_n = 1'b0;
    #1;
    chk("t4_rst_wr", gpio_wr_en, 0);
    chk("t4_rst_drive", dut.drive_en, 0);
    chk("t4_rst_busy", busy, 0);
    chk("t4_rst_ready", req_ready, 0);
    chk("t4_rst_rdata", rsp_rdata, 0);
    chk("t4_rst_addr", gpio_addr, 0);
    cyc(); cyc();
    board_val = 16'hCAFE;
    reset_n = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_addr = 11'h066;
    cyc();
    chk("t4_rel_busy", busy, 0);
    chk("t4_rel_ready", req_ready, 1);
    cyc(); req_valid = 1'b0;
    chk("t4_c1_busy", busy, 1);
    chk("t4_c1_addr", gpio_addr, 11'h066);
    cyc(); cyc(); cyc();
    chk("t4_c4_rsp", rsp_valid, 1);
    chk("t4_c4_rdata", rsp_rdata, 16'hCAFE);
    cyc(); cyc();
    chk("t4_c6_ready", req_ready, 1);
    chk("t4_pulses", rsp_cnt - r0, 1);

    // 6: request inputs change while busy
    req_valid = 1'b1; req_write = 1'b1; req_addr = 11'h155; req_wdata = 16'hBEEF;
    cyc(); req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    cyc();
    chk("t6_c2_addr", gpio_addr, 11'h155);
    chk("t6_c2_data", gpio_bus, 16'hBEEF);
    chk("t6_c2_wr", gpio_wr_en, 1);
    req_addr = 11'h7FF; req_wdata = 16'hFFFF;
    cyc(); cyc();
    chk("t6_c4_addr", gpio_addr, 11'h155);
    chk("t6_c4_data", gpio_bus, 16'hBEEF);
    cyc();
    chk("t6_c5_ready", req_ready, 1);
    chk("t6_c5_addr", gpio_addr, 11'h155);

    // 5: SETUP=3 STROBE=1 HOLD=2 instance
    wr_first = 0; wr_cnt = 0; drv_cnt = 0; rdy_first = 0;
    chk("t5_ready0", r5, 1);
    v5 = 1'b1; w5 = 1'b1; a5 = 11'h0AA; d5 = 16'h1111;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      if (k == 1) begin v5 = 1'b0; a5 = '0; d5 = '0; end
      if (we5) begin
        wr_cnt++;
        if (wr_first == 0) wr_first = k;
      end
      if (u5.drive_en) drv_cnt++;
      if (r5 && rdy_first == 0) rdy_first = k;
      if (k == 6) begin
        chk("t5_c6_data", bus5, 16'h1111);
        chk("t5_c6_addr", ga5, 11'h0AA);
      end
    end
    chk("t5_wr_first", wr_first, 4);
    chk("t5_wr_width", wr_cnt, 1);
    chk("t5_drive_cycles", drv_cnt, 6);
    chk("t5_ready_back", rdy_first, 7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
